// File: rtl/mem_dump_uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mem_dump_uart_pkg
//  Description : Shared FSM encoding, ASCII constants and hex conversion for
//                the memory-dump UART reader.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_dump_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_ADDR   = 3'd1,
        ST_RD_LATCH  = 3'd2,
        ST_LOAD_CHAR = 3'd3,
        ST_WAIT_TX   = 3'd4,
        ST_NEXT_ADDR = 3'd5
    } dump_state_t;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;

    localparam int CHARS_PER_WORD = 6;
    localparam int CHAR_IDX_W     = 3;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] ext;
        ext = {4'h0, nib};
        if (nib < 4'd10) begin
            return ASCII_ZERO + ext;
        end
        return ASCII_UPPER_A + (ext - 8'd10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_dump_uart_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mem_dump_uart_if
//  Description : Read port of the memory bank (address, output enable, data).
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_dump_uart_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic              oe;
    logic [DATA_W-1:0] data;

    modport master (output addr, output oe, input data);
    modport slave  (input addr, input oe, output data);
endinterface
`default_nettype wire

// File: rtl/mem_dump_uart_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 UART transmitter, LSB first, idle high; one frame per
//                accepted send pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [7:0] data,
    input  wire logic       send,
    output logic            tx,
    output logic            ready
);

    localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       STOP_BIT  = 4'd9;

    logic             busy_q, busy_d;
    logic             tx_q, tx_d;
    logic [8:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;

    // shift_q holds the data bits still to go plus the stop bit at the top
    always_comb begin
        busy_d     = busy_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        if (!busy_q) begin
            if (send) begin
                busy_d     = 1'b1;
                tx_d       = 1'b0;
                shift_d    = {1'b1, data};
                bit_cnt_d  = 4'd0;
                baud_cnt_d = '0;
            end
        end else if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_d = '0;
            if (bit_cnt_q == STOP_BIT) begin
                busy_d = 1'b0;
            end else begin
                tx_d      = shift_q[0];
                shift_d   = {1'b1, shift_q[8:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= 1'b0;
            tx_q       <= 1'b1;
            shift_q    <= '1;
            bit_cnt_q  <= 4'd0;
            baud_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ~busy_q;

endmodule
`default_nettype wire

// File: rtl/mem_dump_uart.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mem_dump_uart
//  Description : Walks the memory bank on a start edge and sends every word
//                over the UART as four hex digits followed by CR LF.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_dump_uart
    import mem_dump_uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start,
    mem_dump_uart_if.master  mem,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int                    CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [ADDR_W-1:0]     LAST_ADDR    = ADDR_W'(DEPTH - 1);
    localparam logic [CHAR_IDX_W-1:0] LAST_IDX     = CHAR_IDX_W'(CHARS_PER_WORD - 1);

    dump_state_t            state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   oe_q, oe_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [DATA_W-1:0]      word_q, word_d;
    logic [CHAR_IDX_W-1:0]  idx_q, idx_d;
    logic                   start_q, start_prev_q;

    logic                   start_rise;
    logic                   tx_send;
    logic                   tx_ready;
    logic [7:0]             tx_char;

    assign start_rise = start_q & ~start_prev_q;

    always_comb begin
        tx_char = ASCII_LF;
        case (idx_q)
            3'd0:    tx_char = nibble_to_ascii(word_q[15:12]);
            3'd1:    tx_char = nibble_to_ascii(word_q[11:8]);
            3'd2:    tx_char = nibble_to_ascii(word_q[7:4]);
            3'd3:    tx_char = nibble_to_ascii(word_q[3:0]);
            3'd4:    tx_char = ASCII_CR;
            default: tx_char = ASCII_LF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        word_d  = word_q;
        idx_d   = idx_q;
        tx_send = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_RD_ADDR;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    oe_d    = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_LATCH;
            end
            ST_RD_LATCH: begin
                word_d  = mem.data;
                idx_d   = '0;
                state_d = ST_LOAD_CHAR;
            end
            ST_LOAD_CHAR: begin
                if (tx_ready) begin
                    tx_send = 1'b1;
                    state_d = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                // The next word is fetched while LF is still shifting out so
                // the line break does not stretch the inter-character gap.
                if (idx_q < LAST_IDX) begin
                    if (tx_ready) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_LOAD_CHAR;
                    end
                end else if (tx_ready || (addr_q != LAST_ADDR)) begin
                    state_d = ST_NEXT_ADDR;
                end
            end
            ST_NEXT_ADDR: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_RD_ADDR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            word_q       <= '0;
            idx_q        <= '0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            oe_q         <= oe_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            start_q      <= start;
            start_prev_q <= start_q;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (tx_char),
        .send  (tx_send),
        .tx    (tx),
        .ready (tx_ready)
    );

    assign mem.addr = addr_q;
    assign mem.oe   = oe_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_uart.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_dump_uart
//  Description : Directed self-checking bench for mem_dump_uart at 10 clk/bit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_dump_uart;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        tx;
    logic        busy;
    logic        done;
    logic [15:0] mem [16];

    int n_checks = 0;
    int n_pass   = 0;

    mem_dump_uart_if #(.ADDR_W(4), .DATA_W(16)) mif ();

    assign mif.data = mif.oe ? mem[mif.addr] : 16'hDEAD;

    mem_dump_uart #(
        .CLK_FREQ (1000),
        .BAUD     (100),
        .DEPTH    (16),
        .ADDR_W   (4),
        .DATA_W   (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mem   (mif),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // UART receiver: 100 negedge samples per frame, each bit must be 10 flat samples
    logic [9:0] frames_q [$];
    bit         frame_ok_q [$];
    int         gaps_q [$];
    logic [99:0] samp;
    int          n_samp = 0;
    bit          coll = 1'b0;
    int          gap = 0;
    int          cur_gap = 0;

    always @(negedge clk) begin
        if (rst) begin
            coll   = 1'b0;
            n_samp = 0;
            gap    = 0;
        end else if (!coll) begin
            if (tx === 1'b0) begin
                coll    = 1'b1;
                samp[0] = 1'b0;
                n_samp  = 1;
                cur_gap = gap;
            end else begin
                gap = gap + 1;
            end
        end else begin
            samp[n_samp] = tx;
            n_samp = n_samp + 1;
            if (n_samp == 100) begin
                logic [9:0] bits;
                bit ok;
                ok = 1'b1;
                for (int b = 0; b < 10; b++) begin
                    bits[b] = samp[10*b];
                    for (int s = 1; s < 10; s++) begin
                        if (samp[10*b+s] !== samp[10*b]) ok = 1'b0;
                    end
                end
                if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
                frames_q.push_back(bits);
                frame_ok_q.push_back(ok);
                gaps_q.push_back(cur_gap);
                coll = 1'b0;
                gap  = 0;
            end
        end
    end

    int   done_cnt = 0;
    int   done_bad = 0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            done_cnt = done_cnt + 1;
            if (!(busy_prev === 1'b1 && busy === 1'b0)) done_bad = done_bad + 1;
        end
        busy_prev = busy;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] exp_char(input logic [15:0] w, input int c);
        case (c)
            0:       return hex_ascii(w[15:12]);
            1:       return hex_ascii(w[11:8]);
            2:       return hex_ascii(w[7:4]);
            3:       return hex_ascii(w[3:0]);
            4:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    function automatic logic [7:0] char_at(input int i);
        if (i < frames_q.size()) return frames_q[i][8:1];
        return 8'h00;
    endfunction

    task automatic pulse_start(input int hi_cycles);
        @(negedge clk);
        start = 1'b1;
        repeat (hi_cycles) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_dump(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_busy_rise"}, busy, 1);
        k = 0;
        while (busy !== 1'b0 && k < 15000) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_busy_fall"}, busy, 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_frames(input string tag, input int target);
        int k;
        k = 0;
        while (frames_q.size() < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_frames_arrived"}, (frames_q.size() >= target) ? 1 : 0, 1);
    endtask

    task automatic abort_with_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_dump(input string tag, input int fbase, input int dbase);
        int nf, bad_chr, bad_frm, max_gap;
        nf = frames_q.size() - fbase;
        bad_chr = 0;
        bad_frm = 0;
        max_gap = 0;
        check_val({tag, "_nchars"}, nf, 96);
        for (int i = 0; i < 96 && (fbase + i) < frames_q.size(); i++) begin
            if (frames_q[fbase+i][8:1] !== exp_char(mem[i/6], i % 6)) bad_chr++;
            if (!frame_ok_q[fbase+i]) bad_frm++;
            if (i > 0 && gaps_q[fbase+i] > max_gap) max_gap = gaps_q[fbase+i];
        end
        check_val({tag, "_bad_chars"}, bad_chr, 0);
        check_val({tag, "_bad_frames"}, bad_frm, 0);
        check_val({tag, "_gap_le2"}, (max_gap <= 2) ? 1 : 0, 1);
        check_val({tag, "_done_pulses"}, done_cnt - dbase, 1);
        check_val({tag, "_addr_after"}, mif.addr, 0);
        check_val({tag, "_oe_after"}, mif.oe, 0);
    endtask

    initial begin
        int fb, db, lat;

        for (int i = 0; i < 16; i++) mem[i] = 16'(i) * 16'h1111;

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_tx", tx, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_oe", mif.oe, 0);
        check_val("rst_addr", mif.addr, 0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check_val("idle_no_frames", frames_q.size() + (coll ? 1 : 0), 0);
        check_val("idle_busy", busy, 0);

        // first word 00A5: latency, characters, exact 'A' waveform
        mem[0] = 16'h00A5;
        fb = frames_q.size();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (tx === 1'b0) break;
        end
        check_val("t2_latency_le4", (lat <= 4 && tx === 1'b0) ? 1 : 0, 1);
        @(negedge clk);
        start = 1'b0;
        wait_frames("t2", fb + 6);
        check_val("t2_hex", {char_at(fb), char_at(fb+1), char_at(fb+2), char_at(fb+3)}, 32'h30304135);
        check_val("t2_crlf", {char_at(fb+4), char_at(fb+5)}, 16'h0D0A);
        check_val("t2_A_bits", (fb + 2 < frames_q.size()) ? frames_q[fb+2] : 10'h0, 10'b1010000010);
        check_val("t2_A_timing", (fb + 2 < frames_q.size()) ? frame_ok_q[fb+2] : 1'b0, 1);
        abort_with_reset();

        // full dump of i*1111
        mem[0] = 16'h0000;
        fb = frames_q.size();
        db = done_cnt;
        pulse_start(2);
        wait_dump("t3");
        check_dump("t3", fb, db);
        check_val("t3_last_hex", {char_at(fb+90), char_at(fb+91), char_at(fb+92), char_at(fb+93)}, 32'h46464646);
        check_val("t3_last_crlf", {char_at(fb+94), char_at(fb+95)}, 16'h0D0A);

        // extra start edges while busy are dropped
        fb = frames_q.size();
        db = done_cnt;
        pulse_start(2);
        repeat (8) @(negedge clk);
        pulse_start(2);
        repeat (488) @(negedge clk);
        pulse_start(2);
        wait_dump("t4");
        check_dump("t4", fb, db);

        // asynchronous reset in the middle of the third character
        fb = frames_q.size();
        pulse_start(2);
        wait_frames("t5", fb + 2);
        repeat (30) @(negedge clk);
        check_val("t5_busy_before_rst", busy, 1);
        check_val("t5_tx_mid_char", coll ? 1 : 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t5_async_tx", tx, 1);
        check_val("t5_async_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        fb = frames_q.size();
        pulse_start(2);
        wait_frames("t5b", fb + 6);
        check_val("t5b_hex", {char_at(fb), char_at(fb+1), char_at(fb+2), char_at(fb+3)}, 32'h30303030);
        check_val("t5b_crlf", {char_at(fb+4), char_at(fb+5)}, 16'h0D0A);
        abort_with_reset();

        // start held high for three dump durations: one dump only
        fb = frames_q.size();
        db = done_cnt;
        @(negedge clk);
        start = 1'b1;
        repeat (30000) @(negedge clk);
        check_val("t6_busy_held", busy, 0);
        check_dump("t6", fb, db);
        start = 1'b0;
        repeat (4) @(negedge clk);
        fb = frames_q.size();
        db = done_cnt;
        pulse_start(2);
        wait_dump("t6b");
        check_dump("t6b", fb, db);

        check_val("done_with_busy_fall", done_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
